// File: rtl/quad_uart_wb_arbiter.sv
// quad_uart_wb_arbiter
//   Shares the single Wishbone slave port of quad_uart_top among NUM_MASTERS
//   requesters. Arbitration is round-robin, and a grant lasts for one complete
//   bus tenure, meaning for as long as the owner holds m_cyc_i. If the slave
//   stalls, a watchdog ends the stall and returns err to the owning master.
//
// Ports
//   wb_clk_i, wb_rst_i        clock and synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i    per-master bus controls (one bit per master)
//   m_adr_i/m_dat_i/m_sel_i   per-master address, write data and byte selects
//                             (packed; master i occupies slice i)
//   m_dat_o                   slave read data, broadcast to every master
//   m_ack_o/m_err_o           termination, delivered to the owner only
//   s_*_o                     owner's cycle, forwarded to the slave
//   s_dat_i/s_ack_i/s_err_i   slave response
//   grant_o                   registered one-hot owner; 0 when idle
//
// State table
//   state   | meaning
//   ST_IDLE | no owner; requests are sampled and the next owner is picked
//   ST_OWN  | grant_o owner is connected to the slave
//   ST_TOUT | watchdog fired; err to the owner for one cycle, bus gated off
module quad_uart_wb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_i,
  output logic [DATA_W-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [ADDR_W-1:0]               s_adr_o,
  output logic [DATA_W-1:0]               s_dat_o,
  output logic [DATA_W/8-1:0]             s_sel_o,
  input  logic [DATA_W-1:0]               s_dat_i,
  input  logic                            s_ack_i,
  input  logic                            s_err_i,
  output logic [NUM_MASTERS-1:0]          grant_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_MASTERS);
  // The timer never has to hold more than TIMEOUT_CYCLES-1.
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_TOUT = 2'd2;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

  logic [1:0]             state;
  logic [NUM_MASTERS-1:0] grant;
  logic [IDX_W-1:0]       last;
  logic [TMR_W-1:0]       timer;

  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       cand;
  logic                   winner_vld;
  logic                   has_owner;
  logic                   bus_live;
  logic                   stalled;

  // Convert the one-hot grant to an index.
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[IDX_W'(i)]) owner = IDX_W'(i);
    end
  end

  // Round-robin pick: the scan starts just after the last owner and wraps.
  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_MASTERS);
      if (!winner_vld && m_cyc_i[cand]) begin
        winner     = cand;
        winner_vld = 1'b1;
      end
    end
  end

  assign has_owner = (grant != '0);
  // The bus is gated off during the watchdog cycle, and also while no one owns it.
  assign bus_live  = has_owner && (state == ST_OWN);

  assign s_cyc_o = bus_live & m_cyc_i[owner];
  assign s_stb_o = bus_live & m_stb_i[owner];
  assign s_we_o  = has_owner & m_we_i[owner];
  assign s_adr_o = has_owner ? m_adr_i[int'(owner)*ADDR_W +: ADDR_W] : '0;
  assign s_dat_o = has_owner ? m_dat_i[int'(owner)*DATA_W +: DATA_W] : '0;
  assign s_sel_o = has_owner ? m_sel_i[int'(owner)*SEL_W +: SEL_W] : '0;

  assign m_dat_o = s_dat_i;
  assign grant_o = grant;

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    if (state == ST_OWN) begin
      m_ack_o = {NUM_MASTERS{s_ack_i}} & grant & m_stb_i;
      m_err_o = {NUM_MASTERS{s_err_i}} & grant & m_stb_i;
    end else if (state == ST_TOUT) begin
      m_err_o = grant;
    end
  end

  assign stalled = s_stb_o && !s_ack_i && !s_err_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      grant <= '0;
      last  <= IDX_LAST;
      timer <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (winner_vld) begin
            grant <= NUM_MASTERS'(1) << winner;
            state <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!m_cyc_i[owner]) begin
            // End of tenure. The following IDLE cycle is the dead cycle
            // between two owners.
            grant <= '0;
            last  <= owner;
            state <= ST_IDLE;
            timer <= '0;
          end else if (stalled) begin
            if (timer == TMR_LAST) begin
              state <= ST_TOUT;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end else begin
            timer <= '0;
          end
        end
        ST_TOUT: begin
          // The grant stays put; the owner can retry or drop cyc.
          state <= ST_OWN;
          timer <= '0;
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          last  <= IDX_LAST;
          timer <= '0;
        end
      endcase
    end
  end

endmodule
